// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instruction_fetch_pkg
// Description : Shared state encoding and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0 -- the canonical bubble instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if_id.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : if_id_reg
// Description : IF/ID pipeline register with load enable and bubble flush.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic [31:0]        i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [31:0]        o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  logic [31:0]        r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  // Flush wins over load: a bubble keeps the PC it replaced for traceability
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 32'h0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_pc    <= i_pc;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instruction_fetch
// Description : PC sequencing, redirect handling and fetch-bound halting,
//               feeding an IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic [INSTR_W-1:0] Instruction_Code,
  output logic [31:0]        PC,
  output logic [31:0]        IF_ID_PC,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic               IF_ID_valid,
  output logic               misaligned,
  output logic               halted
);

  // Highest word address that may still be fetched
  localparam logic [31:0] C_LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_misaligned;
  logic         w_br_ok;
  logic         w_br_bad;
  logic         w_en;
  logic         w_flush;

  // Word-aligned redirects are accepted; unaligned ones only raise the flag
  assign w_br_ok  = branch_taken && (branch_target[1:0] == 2'b00);
  assign w_br_bad = branch_taken && (branch_target[1:0] != 2'b00);

  // State, PC and sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_br_bad && (r_state != ST_BOOT)) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  // Next-state / next-PC: branch > stall > bound check > sequential fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_en        = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Instruction memory load cycle: nothing is fetched yet
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_br_ok) begin
          w_pc_nxt = branch_target;
          w_flush  = 1'b1;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (r_pc > C_LAST_PC) begin
          w_state_nxt = ST_HALT;
          w_flush     = 1'b1;
        end else begin
          w_en     = 1'b1;
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_HALT: begin
        if (w_br_ok && (branch_target <= C_LAST_PC)) begin
          w_pc_nxt    = branch_target;
          w_flush     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_PC;
        w_flush     = 1'b1;
      end
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en),
    .i_flush (w_flush),
    .i_pc    (r_pc),
    .i_instr (Instruction_Code),
    .o_pc    (IF_ID_PC),
    .o_instr (IF_ID_Instr),
    .o_valid (IF_ID_valid)
  );

  assign PC         = r_pc;
  assign misaligned = r_misaligned;
  assign halted     = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] Instruction_Code;
  logic [31:0] PC;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_valid;
  logic        misaligned;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word encodes its own address
  assign Instruction_Code = 32'hA000_0000 | PC;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (48)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .Instruction_Code (Instruction_Code),
    .PC               (PC),
    .IF_ID_PC         (IF_ID_PC),
    .IF_ID_Instr      (IF_ID_Instr),
    .IF_ID_valid      (IF_ID_valid),
    .misaligned       (misaligned),
    .halted           (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] ins, input logic v, input logic mis, input logic h);
    check({tag, ".PC"}, PC, pc);
    check({tag, ".IF_ID_PC"}, IF_ID_PC, ipc);
    check({tag, ".IF_ID_Instr"}, IF_ID_Instr, ins);
    check({tag, ".valid"}, {31'b0, IF_ID_valid}, {31'b0, v});
    check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, mis});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
  endtask

  initial begin
    // Reset for two cycles
    reset = 1'b1;
    step();
    step();
    check_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);

    // BOOT cycle: no fetch
    reset = 1'b0;
    step();
    check_all("boot", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);

    // First fetch
    step();
    check_all("fetch0", 32'h4, 32'h0, 32'hA000_0000, 1'b1, 1'b0, 1'b0);
    step();
    check_all("fetch4", 32'h8, 32'h4, 32'hA000_0004, 1'b1, 1'b0, 1'b0);

    // Stall for three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 32'h8, 32'h4, 32'hA000_0004, 1'b1, 1'b0, 1'b0);
    end
    stall = 1'b0;
    step();
    check_all("resume", 32'hC, 32'h8, 32'hA000_0008, 1'b1, 1'b0, 1'b0);

    // Branch wins over stall
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h10;
    step();
    check_all("br_stall", 32'h10, 32'hC, NOP, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    branch_taken = 1'b0;
    step();
    check_all("after_br", 32'h14, 32'h10, 32'hA000_0010, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect ignored apart from the sticky flag
    branch_taken = 1'b1;
    branch_target = 32'h0E;
    step();
    check_all("misal", 32'h18, 32'h14, 32'hA000_0014, 1'b1, 1'b1, 1'b0);
    branch_taken = 1'b0;

    // Run sequentially through the last word (44)
    for (int i = 0; i < 6; i++) step();
    check_all("last", 32'd48, 32'd44, 32'hA000_002C, 1'b1, 1'b1, 1'b0);

    // Out of bounds: halt with a bubble
    step();
    check_all("halt", 32'd48, 32'd48, NOP, 1'b0, 1'b1, 1'b1);
    step();
    check_all("halt_hold", 32'd48, 32'd48, NOP, 1'b0, 1'b1, 1'b1);

    // Branch out of range stays halted
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    check_all("halt_br40", 32'd48, 32'd48, NOP, 1'b0, 1'b1, 1'b1);

    // Branch to 0 leaves HALT
    branch_target = 32'h0;
    step();
    check_all("halt_br0", 32'h0, 32'd48, NOP, 1'b0, 1'b1, 1'b0);
    branch_taken = 1'b0;
    step();
    check_all("rerun", 32'h4, 32'h0, 32'hA000_0000, 1'b1, 1'b1, 1'b0);

    // Run back into HALT: fetch 4..44, then the bound check
    for (int i = 0; i < 11; i++) step();
    check_all("last2", 32'd48, 32'd44, 32'hA000_002C, 1'b1, 1'b1, 1'b0);
    step();
    check_all("halt2", 32'd48, 32'd48, NOP, 1'b0, 1'b1, 1'b1);

    // Reset in HALT overrides a simultaneous branch and stall
    reset = 1'b1;
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h8;
    step();
    check_all("reset_halt", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
